// File: rtl/indirect_accum_if.sv
// rtl/indirect_accum_if.sv - sample/strobe inputs and frame result outputs of indirect_accum
interface indirect_accum_if #(
    parameter int COE_BW = 42,
    parameter int ACC_BW = 64,
    parameter int CNT_BW = 16
);
    logic                     i_frame_start;
    logic                     i_frame_end;
    logic                     i_valid;
    logic signed [COE_BW-1:0] i_Ax [6];
    logic signed [COE_BW-1:0] i_Ay [6];
    logic signed [COE_BW-1:0] i_diffs_x;
    logic signed [COE_BW-1:0] i_diffs_y;
    logic signed [ACC_BW-1:0] o_H [21];
    logic signed [ACC_BW-1:0] o_b [6];
    logic [CNT_BW-1:0]        o_cnt;
    logic                     o_done;

    modport master (
        output i_frame_start, i_frame_end, i_valid, i_Ax, i_Ay, i_diffs_x, i_diffs_y,
        input  o_H, o_b, o_cnt, o_done
    );

    modport slave (
        input  i_frame_start, i_frame_end, i_valid, i_Ax, i_Ay, i_diffs_x, i_diffs_y,
        output o_H, o_b, o_cnt, o_done
    );
endinterface

// File: rtl/indirect_accum.sv
// rtl/indirect_accum.sv - pipelined per-frame accumulation of H = sum(A^T A) and b = sum(A^T r)
module indirect_accum #(
    parameter int COE_BW = 42,
    parameter int MUL    = 20,
    parameter int ACC_BW = 64,
    parameter int CNT_BW = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    indirect_accum_if.slave bus
);
    localparam int PW = 2 * COE_BW;
    localparam int EW = (ACC_BW > PW) ? ACC_BW : PW;

    // Full-width product, floor-shifted by MUL, then fitted to ACC_BW (sign-extend or wrap).
    function automatic logic signed [ACC_BW-1:0] scale(input logic signed [COE_BW-1:0] a,
                                                       input logic signed [COE_BW-1:0] b);
        logic signed [PW-1:0] p;
        logic signed [EW-1:0] e;
        p = PW'(a) * PW'(b);
        e = EW'(p);
        return ACC_BW'(e >>> MUL);
    endfunction

    logic signed [ACC_BW-1:0] w_px_h [21];
    logic signed [ACC_BW-1:0] w_py_h [21];
    logic signed [ACC_BW-1:0] w_px_b [6];
    logic signed [ACC_BW-1:0] w_py_b [6];

    logic signed [ACC_BW-1:0] r_px_h [21];
    logic signed [ACC_BW-1:0] r_py_h [21];
    logic signed [ACC_BW-1:0] r_px_b [6];
    logic signed [ACC_BW-1:0] r_py_b [6];
    logic signed [ACC_BW-1:0] r_term_h [21];
    logic signed [ACC_BW-1:0] r_term_b [6];
    logic signed [ACC_BW-1:0] r_acc_h [21];
    logic signed [ACC_BW-1:0] r_acc_b [6];
    logic [CNT_BW-1:0]        r_cnt;
    logic signed [ACC_BW-1:0] r_H [21];
    logic signed [ACC_BW-1:0] r_b [6];
    logic [CNT_BW-1:0]        r_cnt_out;
    logic                     r_done;

    logic r_valid_d1, r_valid_d2;
    logic r_start_d1, r_start_d2;
    logic r_end_d1, r_end_d2, r_end_d3;

    // Upper-triangle index for (i,j), j>=i, row-major over a 6x6 matrix.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_row
            for (gj = gi; gj < 6; gj++) begin : g_col
                localparam int K = gi * 6 - (gi * (gi - 1)) / 2 + (gj - gi);
                assign w_px_h[K] = scale(bus.i_Ax[gi], bus.i_Ax[gj]);
                assign w_py_h[K] = scale(bus.i_Ay[gi], bus.i_Ay[gj]);
            end
            assign w_px_b[gi] = scale(bus.i_Ax[gi], bus.i_diffs_x);
            assign w_py_b[gi] = scale(bus.i_Ay[gi], bus.i_diffs_y);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_px_h     <= '{default: '0};
            r_py_h     <= '{default: '0};
            r_px_b     <= '{default: '0};
            r_py_b     <= '{default: '0};
            r_term_h   <= '{default: '0};
            r_term_b   <= '{default: '0};
            r_valid_d1 <= 1'b0;
            r_valid_d2 <= 1'b0;
            r_start_d1 <= 1'b0;
            r_start_d2 <= 1'b0;
            r_end_d1   <= 1'b0;
            r_end_d2   <= 1'b0;
        end else begin
            r_px_h     <= w_px_h;
            r_py_h     <= w_py_h;
            r_px_b     <= w_px_b;
            r_py_b     <= w_py_b;
            for (int k = 0; k < 21; k++) r_term_h[k] <= r_px_h[k] + r_py_h[k];
            for (int k = 0; k < 6; k++)  r_term_b[k] <= r_px_b[k] + r_py_b[k];
            r_valid_d1 <= bus.i_valid;
            r_valid_d2 <= r_valid_d1;
            r_start_d1 <= bus.i_frame_start;
            r_start_d2 <= r_start_d1;
            r_end_d1   <= bus.i_frame_end;
            r_end_d2   <= r_end_d1;
        end
    end

    // A start discards prior contents; its own sample (if valid) seeds the new frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_h  <= '{default: '0};
            r_acc_b  <= '{default: '0};
            r_cnt    <= '0;
            r_end_d3 <= 1'b0;
        end else begin
            if (r_start_d2) begin
                for (int k = 0; k < 21; k++) r_acc_h[k] <= r_valid_d2 ? r_term_h[k] : '0;
                for (int k = 0; k < 6; k++)  r_acc_b[k] <= r_valid_d2 ? r_term_b[k] : '0;
                r_cnt <= r_valid_d2 ? CNT_BW'(1) : '0;
            end else if (r_valid_d2) begin
                for (int k = 0; k < 21; k++) r_acc_h[k] <= r_acc_h[k] + r_term_h[k];
                for (int k = 0; k < 6; k++)  r_acc_b[k] <= r_acc_b[k] + r_term_b[k];
                r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + CNT_BW'(1);
            end
            r_end_d3 <= r_end_d2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_H       <= '{default: '0};
            r_b       <= '{default: '0};
            r_cnt_out <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= r_end_d3;
            if (r_end_d3) begin
                r_H       <= r_acc_h;
                r_b       <= r_acc_b;
                r_cnt_out <= r_cnt;
            end
        end
    end

    assign bus.o_H    = r_H;
    assign bus.o_b    = r_b;
    assign bus.o_cnt  = r_cnt_out;
    assign bus.o_done = r_done;
endmodule

// File: tb/tb_indirect_accum.sv
// tb/tb_indirect_accum.sv - directed and randomized checks of indirect_accum against a frame-level model
module tb_indirect_accum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st, en, vl;
    logic signed [41:0] ax [6];
    logic signed [41:0] ay [6];
    logic signed [41:0] dx, dy;

    indirect_accum_if #(.COE_BW(42), .ACC_BW(64), .CNT_BW(16)) bus ();

    assign bus.i_frame_start = st;
    assign bus.i_frame_end   = en;
    assign bus.i_valid       = vl;
    assign bus.i_Ax          = ax;
    assign bus.i_Ay          = ay;
    assign bus.i_diffs_x     = dx;
    assign bus.i_diffs_y     = dy;

    indirect_accum #(.COE_BW(42), .MUL(20), .ACC_BW(64), .CNT_BW(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    logic [63:0] m_h [21];
    logic [63:0] m_b [6];
    int          m_cnt;
    logic        ev_valid [4];
    logic [63:0] ev_h [4][21];
    logic [63:0] ev_b [4][6];
    int          ev_cnt [4];
    logic [63:0] e_h [21];
    logic [63:0] e_b [6];
    int          e_cnt;
    logic        e_done;

    logic [63:0] one, minus_one;
    int done_seen;
    logic [15:0] cnt_seen;

    // Real-valued product a*b/2^20 rounded toward minus infinity, wrapped to 64 bits.
    function automatic logic [63:0] fx(input logic signed [41:0] a, input logic signed [41:0] b);
        logic signed [83:0] pa, pb, p, d, q, r;
        pa = a;
        pb = b;
        p = pa * pb;
        d = 84'sd1048576;
        q = p / d;
        r = p % d;
        if (r != 0 && p < 0) q = q - 84'sd1;
        return q[63:0];
    endfunction

    function automatic logic signed [41:0] rnd42();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[41:0];
    endfunction

    task automatic rand_data();
        for (int i = 0; i < 6; i++) begin
            ax[i] = rnd42();
            ay[i] = rnd42();
        end
        dx = rnd42();
        dy = rnd42();
    endtask

    task automatic zero_data();
        for (int i = 0; i < 6; i++) begin
            ax[i] = '0;
            ay[i] = '0;
        end
        dx = '0;
        dy = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model by the sample just presented, then compare every output.
    task automatic step();
        logic [63:0] th [21];
        logic [63:0] tb [6];
        int k, slot;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 21; i++) begin m_h[i] = '0; e_h[i] = '0; end
            for (int i = 0; i < 6; i++)  begin m_b[i] = '0; e_b[i] = '0; end
            for (int i = 0; i < 4; i++)  ev_valid[i] = 1'b0;
            m_cnt  = 0;
            e_cnt  = 0;
            e_done = 1'b0;
        end else begin
            k = 0;
            for (int i = 0; i < 6; i++) begin
                for (int j = i; j < 6; j++) begin
                    th[k] = fx(ax[i], ax[j]) + fx(ay[i], ay[j]);
                    k++;
                end
                tb[i] = fx(ax[i], dx) + fx(ay[i], dy);
            end
            if (st) begin
                for (int i = 0; i < 21; i++) m_h[i] = vl ? th[i] : 64'd0;
                for (int i = 0; i < 6; i++)  m_b[i] = vl ? tb[i] : 64'd0;
                m_cnt = vl ? 1 : 0;
            end else if (vl) begin
                for (int i = 0; i < 21; i++) m_h[i] = m_h[i] + th[i];
                for (int i = 0; i < 6; i++)  m_b[i] = m_b[i] + tb[i];
                if (m_cnt != 65535) m_cnt++;
            end
            if (en) begin
                slot = (edge_no + 3) % 4;
                ev_valid[slot] = 1'b1;
                ev_h[slot]     = m_h;
                ev_b[slot]     = m_b;
                ev_cnt[slot]   = m_cnt;
            end
            slot   = edge_no % 4;
            e_done = ev_valid[slot];
            if (ev_valid[slot]) begin
                e_h = ev_h[slot];
                e_b = ev_b[slot];
                e_cnt = ev_cnt[slot];
                ev_valid[slot] = 1'b0;
            end
        end
        edge_no++;
        chk($sformatf("done@%0d", edge_no), {63'd0, bus.o_done}, {63'd0, e_done});
        chk($sformatf("cnt@%0d", edge_no), {48'd0, bus.o_cnt}, 64'(e_cnt));
        for (int i = 0; i < 21; i++) chk($sformatf("H%0d@%0d", i, edge_no), bus.o_H[i], e_h[i]);
        for (int i = 0; i < 6; i++)  chk($sformatf("b%0d@%0d", i, edge_no), bus.o_b[i], e_b[i]);
    endtask

    task automatic idle(input int n);
        st = 1'b0; en = 1'b0; vl = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        one       = 64'd1 << 20;
        minus_one = '1;
        rst = 1'b1; st = 1'b0; en = 1'b0; vl = 1'b0;
        for (int i = 0; i < 4; i++) ev_valid[i] = 1'b0;

        // reset with random strobes and data
        for (int i = 0; i < 2; i++) begin
            rand_data();
            st = 1'($urandom_range(1)); en = 1'($urandom_range(1)); vl = 1'($urandom_range(1));
            step();
            chk("rst_done", {63'd0, bus.o_done}, 64'd0);
            chk("rst_cnt", {48'd0, bus.o_cnt}, 64'd0);
        end
        rst = 1'b0;
        idle(6);

        // single-sample frame, start and end together
        zero_data();
        ax[0] = 42'sd1 <<< 20; ay[1] = 42'sd2 <<< 20; dx = 42'sd3 <<< 20; dy = -(42'sd1 <<< 20);
        st = 1'b1; en = 1'b1; vl = 1'b1;
        step();
        idle(3);
        chk("s1_done", {63'd0, bus.o_done}, 64'd1);
        chk("s1_H0", bus.o_H[0], one);
        chk("s1_H6", bus.o_H[6], 4 * one);
        chk("s1_b0", bus.o_b[0], 3 * one);
        chk("s1_b1", bus.o_b[1], 64'd0 - 2 * one);
        chk("s1_cnt", {48'd0, bus.o_cnt}, 64'd1);
        chk("s1_H1", bus.o_H[1], 64'd0);
        idle(2);

        // three repeated samples, two idle cycles, end on an invalid cycle
        st = 1'b1; vl = 1'b1; step();
        st = 1'b0; step(); step();
        vl = 1'b0; step(); step();
        en = 1'b1; step();
        idle(3);
        chk("s3_done", {63'd0, bus.o_done}, 64'd1);
        chk("s3_H0", bus.o_H[0], 3 * one);
        chk("s3_H6", bus.o_H[6], 12 * one);
        chk("s3_b0", bus.o_b[0], 9 * one);
        chk("s3_b1", bus.o_b[1], 64'd0 - 6 * one);
        chk("s3_cnt", {48'd0, bus.o_cnt}, 64'd3);
        idle(2);

        // restart mid-frame: only samples 3..5 reported, one done pulse
        done_seen = 0;
        cnt_seen = '0;
        for (int s = 1; s <= 5; s++) begin
            rand_data();
            st = (s == 1 || s == 3); en = (s == 5); vl = 1'b1;
            step();
            if (bus.o_done === 1'b1) begin done_seen++; cnt_seen = bus.o_cnt; end
        end
        st = 1'b0; en = 1'b0; vl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.o_done === 1'b1) begin done_seen++; cnt_seen = bus.o_cnt; end
        end
        chk("restart_dones", 64'(done_seen), 64'd1);
        chk("restart_cnt", {48'd0, cnt_seen}, 64'd3);

        // floor shift of a tiny negative product
        zero_data();
        ax[0] = -42'sd1; dx = 42'sd1;
        st = 1'b1; en = 1'b1; vl = 1'b1;
        step();
        idle(3);
        chk("floor_done", {63'd0, bus.o_done}, 64'd1);
        chk("floor_b0", bus.o_b[0], minus_one);
        chk("floor_H0", bus.o_H[0], 64'd0);
        idle(2);

        // reset one cycle after a frame_end suppresses the report
        rand_data();
        st = 1'b1; en = 1'b1; vl = 1'b1;
        step();
        st = 1'b0; en = 1'b0; vl = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.o_done !== 1'b0) done_seen++;
        end
        chk("rstfly_dones", 64'(done_seen), 64'd0);
        chk("rstfly_b0", bus.o_b[0], 64'd0);
        chk("rstfly_H0", bus.o_H[0], 64'd0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rand_data();
            st  = ($urandom_range(15) == 0);
            en  = ($urandom_range(11) == 0);
            vl  = ($urandom_range(3) != 0);
            rst = ($urandom_range(149) == 0);
            step();
        end
        rst = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/indirect_accum.md
INDIRECT_ACCUM -- requirements
Module: indirect_accum

Interface
REQ-001 Parameter COE_BW, default 42: width of every input coefficient and residual, two's complement, MUL fractional bits.
REQ-002 Parameter MUL, default 20: fractional bits of inputs and of all accumulated outputs.
REQ-003 Parameter ACC_BW, default 64: width of each accumulator and output entry, two's complement.
REQ-004 Parameter CNT_BW, default 16: width of the sample counter.
REQ-005 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_frame_start  in  1  one-cycle pulse; first sample cycle of a frame.
REQ-008 i_frame_end  in  1  one-cycle pulse; last sample cycle of a frame.
REQ-009 i_valid  in  1  sample qualifier for i_Ax, i_Ay, i_diffs_x, i_diffs_y.
REQ-010 i_Ax [6]  in  COE_BW each  x-row Jacobian coefficients 0..5.
REQ-011 i_Ay [6]  in  COE_BW each  y-row Jacobian coefficients 0..5.
REQ-012 i_diffs_x, i_diffs_y  in  COE_BW each  reprojection residuals.
REQ-013 o_H [21]  out  ACC_BW each  upper triangle of H = sum(A^T A), row-major: (0,0)=0 .. (0,5)=5, (1,1)=6 .. (1,5)=10, (2,2)=11 .. (5,5)=20.
REQ-014 o_b [6]  out  ACC_BW each  b = sum(A^T r).
REQ-015 o_cnt  out  CNT_BW  number of valid samples in the reported frame.
REQ-016 o_done  out  1  one-cycle pulse; o_H, o_b and o_cnt were updated on this cycle.

Function
REQ-017 Stage 1 (register): the block SHALL form products p = Ax_i*Ax_j, Ay_i*Ay_j for i<=j, plus Ax_i*diffs_x and Ay_i*diffs_y, as full-width signed products.
REQ-018 Each product SHALL be arithmetically right-shifted by MUL (floor) and sign-extended to ACC_BW.
REQ-019 Stage 2 (register): the block SHALL form term_k = x-product_k + y-product_k for all 21 H terms and all 6 b terms.
REQ-020 Stage 3: a term SHALL be added to its accumulator only when the valid delayed 2 cycles is high; the counter increments by 1 under the same condition.
REQ-021 Accumulation SHALL be modulo 2^ACC_BW, with no saturation.
REQ-022 The counter SHALL saturate at 2^CNT_BW-1.
REQ-023 i_frame_start and i_frame_end SHALL be delayed 2 cycles to align with stage 3.
REQ-024 Aligned frame_start SHALL load the accumulators with that cycle's term if valid, else 0, and load the counter with 1 if valid, else 0; prior contents are discarded.
REQ-025 Aligned frame_end SHALL latch accumulator and counter values, including that cycle's sample, into o_H/o_b/o_cnt one cycle later and pulse o_done for that cycle.
REQ-026 Latency: a frame_end at input cycle t SHALL give o_done high at cycle t+4.
REQ-027 frame_start and frame_end on the same cycle SHALL report a frame of at most one sample.
REQ-028 frame_start while a frame is open SHALL restart the frame, with no o_done for the abandoned frame.
REQ-029 frame_end with no preceding frame_start SHALL report the current accumulator contents.
REQ-030 Samples with i_valid low SHALL change nothing; back-to-back valid samples SHALL be accepted every cycle, with no backpressure.
REQ-031 o_H, o_b and o_cnt SHALL hold their values between o_done pulses and SHALL be unaffected by a new frame_start.

Reset
REQ-032 While i_rst is high at a clock edge, all pipeline registers, accumulators, the counter, the delayed strobes, o_H, o_b, o_cnt and o_done SHALL be cleared to 0.
REQ-033 Reset asserted mid-frame or with a frame_end in flight SHALL suppress o_done for that frame; operation SHALL resume on the first edge after i_rst falls.

Verification (values in real units; 1.0 = 2^MUL)
REQ-034 Assert i_rst for 2 cycles with random inputs -> all outputs 0 and o_done 0 throughout, and no o_done afterwards without a frame_end.
REQ-035 At cycle t: frame_start=frame_end=valid=1, Ax0=1.0, Ay1=2.0, other A=0, diffs_x=3.0, diffs_y=-1.0 -> o_done at t+4; H[0]=1.0, H[6]=4.0, b[0]=3.0, b[1]=-2.0, cnt=1, all other entries 0.
REQ-036 Same sample on 3 consecutive cycles, plus 2 valid-low cycles before frame_end -> H[0]=3.0, H[6]=12.0, b[0]=9.0, b[1]=-6.0, cnt=3.
REQ-037 Frame with 5 samples, second frame_start after sample 2, frame_end after sample 5 -> a single o_done; cnt=3 and sums cover samples 3-5 only.
REQ-038 Ax0 = -1 LSB, diffs_x = 1 LSB, all other inputs 0, single-sample frame -> b[0] = -1 LSB (floor shift) and H[0] = 0.
REQ-039 i_rst pulsed 1 cycle after an input frame_end -> no o_done; outputs read 0.
